// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, colour type and sync level helper.
package vga_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;
  localparam int unsigned DefColorW  = 1;

  typedef struct packed {
    logic [DefColorW-1:0] r;
    logic [DefColorW-1:0] g;
    logic [DefColorW-1:0] b;
  } rgb_t;

  // Active level of the sync pin equals pol.
  function automatic logic sync_level(input logic raw, input logic pol);
    return raw ^ ~pol;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-side bundle of the VGA generator: colour in, coordinates, syncs, strobes out.
interface vga_sync_gen_if #(
    parameter int unsigned XW      = 10,
    parameter int unsigned YW      = 10,
    parameter int unsigned COLOR_W = 1
);
    logic [3*COLOR_W-1:0] rgb_in;
    logic [XW-1:0]        x_pos;
    logic [YW-1:0]        y_pos;
    logic                 de;
    logic                 hsync;
    logic                 vsync;
    logic [3*COLOR_W-1:0] color;
    logic                 frame_start;
    logic                 game_tick;

    modport master (
        input  rgb_in,
        output x_pos, y_pos, de, hsync, vsync, color, frame_start, game_tick
    );

    modport slave (
        output rgb_in,
        input  x_pos, y_pos, de, hsync, vsync, color, frame_start, game_tick
    );
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping axis counter 0..TOTAL-1; wrap flags the increment that returns to 0.
module vga_axis_counter #(
    parameter int unsigned TOTAL = 8,
    parameter int unsigned W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap  = inc && (cnt_q == W'(TOTAL - 1));
        cnt_d = cnt_q;
        if (clr || wrap) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised VGA timing generator: counters, registered syncs/colour, frame and game strobes.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DefHActive,
    parameter int unsigned H_FP        = DefHFp,
    parameter int unsigned H_SYNC      = DefHSync,
    parameter int unsigned H_BP        = DefHBp,
    parameter int unsigned V_ACTIVE    = DefVActive,
    parameter int unsigned V_FP        = DefVFp,
    parameter int unsigned V_SYNC      = DefVSync,
    parameter int unsigned V_BP        = DefVBp,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned COLOR_W     = DefColorW,
    parameter int unsigned PIX_DIV     = 1,
    parameter int unsigned TICK_FRAMES = 1
) (
    input logic            clk,
    input logic            rst,
    vga_sync_gen_if.master bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned XW      = $clog2(H_TOTAL);
    localparam int unsigned YW      = $clog2(V_TOTAL);
    localparam int unsigned PW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned FW      = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
    localparam int unsigned CW      = 3 * COLOR_W;

    logic [PW-1:0] presc_q, presc_d;
    logic          pix_en;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          x_wrap, y_wrap;
    logic [31:0]   x_ext, y_ext;
    logic          de, hs_raw, vs_raw, vblank_evt;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic [CW-1:0] color_q, color_d;
    logic          fs_q, fs_d, gt_q, gt_d;
    logic [FW-1:0] frame_q, frame_d;

    assign pix_en  = (presc_q == '0);
    assign presc_d = (presc_q == PW'(PIX_DIV - 1)) ? '0 : presc_q + PW'(1);

    vga_axis_counter #(
        .TOTAL(H_TOTAL),
        .W    (XW)
    ) u_x_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pix_en),
        .clr (1'b0),
        .cnt (x_cnt),
        .wrap(x_wrap)
    );

    // y only steps when x wraps, so its wrap marks the last pixel of the frame.
    vga_axis_counter #(
        .TOTAL(V_TOTAL),
        .W    (YW)
    ) u_y_cnt (
        .clk (clk),
        .rst (rst),
        .inc (x_wrap),
        .clr (1'b0),
        .cnt (y_cnt),
        .wrap(y_wrap)
    );

    assign x_ext      = 32'(x_cnt);
    assign y_ext      = 32'(y_cnt);
    assign de         = (x_ext < H_ACTIVE) && (y_ext < V_ACTIVE);
    assign hs_raw     = (x_ext >= H_ACTIVE + H_FP) && (x_ext < H_ACTIVE + H_FP + H_SYNC);
    assign vs_raw     = (y_ext >= V_ACTIVE + V_FP) && (y_ext < V_ACTIVE + V_FP + V_SYNC);
    assign vblank_evt = x_wrap && (y_ext == V_ACTIVE - 1);

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        color_d = color_q;
        frame_d = frame_q;
        if (pix_en) begin
            hsync_d = sync_level(hs_raw, SYNC_POL);
            vsync_d = sync_level(vs_raw, SYNC_POL);
            color_d = de ? bus.rgb_in : '0;
        end
        if (vblank_evt) begin
            frame_d = (frame_q == FW'(TICK_FRAMES - 1)) ? '0 : frame_q + FW'(1);
        end
        // frame_start wins if both strobes ever coincide.
        fs_d = y_wrap;
        gt_d = vblank_evt && (frame_q == FW'(TICK_FRAMES - 1)) && !y_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            color_q <= '0;
            fs_q    <= 1'b0;
            gt_q    <= 1'b0;
            frame_q <= '0;
        end else begin
            presc_q <= presc_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            color_q <= color_d;
            fs_q    <= fs_d;
            gt_q    <= gt_d;
            frame_q <= frame_d;
        end
    end

    assign bus.x_pos       = x_cnt;
    assign bus.y_pos       = y_cnt;
    assign bus.de          = de;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.color       = color_q;
    assign bus.frame_start = fs_q;
    assign bus.game_tick   = gt_q;

`ifndef SYNTHESIS
    vblank_nonzero: assert property (@(posedge clk) (V_FP + V_SYNC + V_BP) != 0);
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomised-colour bench: three generator variants checked every clk against an arithmetic model.
module tb_vga_sync_gen;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 1;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FT  = HT * VT;

    typedef struct packed {
        logic [3:0]  x;
        logic [2:0]  y;
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] col;
        logic        fs;
        logic        gt;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [11:0] rgb [3];
    obs_t obs [3];

    int pd_t [3] = '{1, 2, 1};
    int tk_t [3] = '{1, 1, 3};
    bit pol_t [3] = '{1'b0, 1'b1, 1'b0};

    bit          exp_hs [3];
    bit          exp_vs [3];
    logic [11:0] exp_col [3];
    bit          exp_fs [3];
    bit          exp_gt [3];

    int k;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_sync_gen_if #(.XW(4), .YW(3), .COLOR_W(4)) bus_a ();
    vga_sync_gen_if #(.XW(4), .YW(3), .COLOR_W(4)) bus_b ();
    vga_sync_gen_if #(.XW(4), .YW(3), .COLOR_W(4)) bus_c ();

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b0), .COLOR_W(4), .PIX_DIV(1), .TICK_FRAMES(1)
    ) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b1), .COLOR_W(4), .PIX_DIV(2), .TICK_FRAMES(1)
    ) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b0), .COLOR_W(4), .PIX_DIV(1), .TICK_FRAMES(3)
    ) u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    assign bus_a.rgb_in = rgb[0];
    assign bus_b.rgb_in = rgb[1];
    assign bus_c.rgb_in = rgb[2];

    assign obs[0] = {bus_a.x_pos, bus_a.y_pos, bus_a.de, bus_a.hsync, bus_a.vsync,
                     bus_a.color, bus_a.frame_start, bus_a.game_tick};
    assign obs[1] = {bus_b.x_pos, bus_b.y_pos, bus_b.de, bus_b.hsync, bus_b.vsync,
                     bus_b.color, bus_b.frame_start, bus_b.game_tick};
    assign obs[2] = {bus_c.x_pos, bus_c.y_pos, bus_c.de, bus_c.hsync, bus_c.vsync,
                     bus_c.color, bus_c.frame_start, bus_c.game_tick};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pixels consumed after k clk edges since reset release (first edge is a pixel edge).
    function automatic int pix_of(input int kk, input int pd);
        return (kk + pd - 1) / pd;
    endfunction

    task automatic model_reset();
        k = 0;
        for (int d = 0; d < 3; d++) begin
            exp_hs[d]  = !pol_t[d];
            exp_vs[d]  = !pol_t[d];
            exp_col[d] = 12'h000;
            exp_fs[d]  = 1'b0;
            exp_gt[d]  = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            int p, x, y;
            bit de;
            p  = pix_of(k, pd_t[d]);
            x  = p % HT;
            y  = (p / HT) % VT;
            de = (x < HA) && (y < VA);
            check_val($sformatf("d%0d_x_pos@%0d", d, k), 32'(obs[d].x), 32'(x));
            check_val($sformatf("d%0d_y_pos@%0d", d, k), 32'(obs[d].y), 32'(y));
            check_val($sformatf("d%0d_de@%0d", d, k), 32'(obs[d].de), 32'(de));
            check_val($sformatf("d%0d_hsync@%0d", d, k), 32'(obs[d].hs), 32'(exp_hs[d]));
            check_val($sformatf("d%0d_vsync@%0d", d, k), 32'(obs[d].vs), 32'(exp_vs[d]));
            check_val($sformatf("d%0d_color@%0d", d, k), 32'(obs[d].col), 32'(exp_col[d]));
            check_val($sformatf("d%0d_frame_start@%0d", d, k), 32'(obs[d].fs), 32'(exp_fs[d]));
            check_val($sformatf("d%0d_game_tick@%0d", d, k), 32'(obs[d].gt), 32'(exp_gt[d]));
        end
    endtask

    // Pick fresh colours and compute what the next edge should register.
    task automatic predict();
        for (int d = 0; d < 3; d++) begin
            int p, x, y;
            bit de;
            p      = pix_of(k, pd_t[d]);
            x      = p % HT;
            y      = (p / HT) % VT;
            de     = (x < HA) && (y < VA);
            rgb[d] = 12'($urandom);
            if (k % pd_t[d] == 0) begin
                exp_hs[d]  = (x >= HA + HFP && x < HA + HFP + HSW) ? pol_t[d] : !pol_t[d];
                exp_vs[d]  = (y >= VA + VFP && y < VA + VFP + VSW) ? pol_t[d] : !pol_t[d];
                exp_col[d] = de ? rgb[d] : 12'h000;
                exp_fs[d]  = (p % FT) == FT - 1;
                exp_gt[d]  = (x == HT - 1) && (y == VA - 1) && (((p / FT) + 1) % tk_t[d] == 0);
            end else begin
                exp_fs[d] = 1'b0;
                exp_gt[d] = 1'b0;
            end
        end
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        k++;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int guard;
        for (int d = 0; d < 3; d++) rgb[d] = 12'h000;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        repeat (1400) step();

        // Reset in the middle of a frame, at pixel (6,2) of the PIX_DIV=1 variant.
        guard = 0;
        while (!(pix_of(k, 1) % HT == 6 && (pix_of(k, 1) / HT) % VT == 2) && guard < 300) begin
            step();
            guard++;
        end
        check_val("reset_point_reached", 32'(guard < 300), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;

        repeat (700) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
